// File: rtl/gcd_master.sv
// Request/response front end for an external iterative GCD core.
// Handles zero-operand bypass, core handshake with stale-ready masking, and a RUN timeout.
module gcd_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_timeout,
    output logic [7:0] gcd_a,
    output logic [7:0] gcd_b,
    output logic       gcd_run,
    input  logic       gcd_ready,
    input  logic [7:0] gcd_y
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] gcd_a_q, gcd_a_d;
    logic [7:0] gcd_b_q, gcd_b_d;
    logic [7:0] rsp_y_q, rsp_y_d;
    logic       rsp_timeout_q, rsp_timeout_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            gcd_a_q       <= 8'd0;
            gcd_b_q       <= 8'd0;
            rsp_y_q       <= 8'd0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            gcd_a_q       <= gcd_a_d;
            gcd_b_q       <= gcd_b_d;
            rsp_y_q       <= rsp_y_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gcd_a_d       = gcd_a_q;
        gcd_b_d       = gcd_b_q;
        rsp_y_d       = rsp_y_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    gcd_a_d = req_a;
                    gcd_b_d = req_b;
                    if (req_a != 8'd0 && req_b != 8'd0) begin
                        state_d = LOAD;
                    end else begin
                        // gcd(x,0) = x, and gcd(0,0) = 0 falls out of the OR
                        rsp_y_d       = req_a | req_b;
                        rsp_timeout_d = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            LOAD: begin
                cnt_d   = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                // The core's ready may still be high from the last operation on cycle 0
                if (cnt_q != 8'd0 && gcd_ready) begin
                    rsp_y_d       = gcd_y;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    rsp_y_d       = 8'd0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign gcd_run     = (state_q == RUN);
    assign rsp_y       = rsp_y_q;
    assign rsp_timeout = rsp_timeout_q;
    assign gcd_a       = gcd_a_q;
    assign gcd_b       = gcd_b_q;

endmodule

// File: tb/tb_gcd_master.sv
// Self-checking bench for gcd_master: transaction-level reference model, behavioural
// GCD core with programmable ready delay, directed scenarios and randomized traffic.
module tb_gcd_master;

    localparam int TO = 64;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic       rsp_timeout;
    logic [7:0] gcd_a;
    logic [7:0] gcd_b;
    logic       gcd_run;
    logic       gcd_ready;
    logic [7:0] gcd_y;

    gcd_master #(.TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_timeout(rsp_timeout),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_run    (gcd_run),
        .gcd_ready  (gcd_ready),
        .gcd_y      (gcd_y)
    );

    int checks = 0;
    int failures = 0;

    int cfg_d = 0;
    bit cfg_stale = 0;
    int rsp_mode = 0;

    bit         m_init = 0;
    bit         m_busy = 0;
    bit         m_bypass = 0;
    int         m_rel = 0;
    int         m_c = 0;
    int         m_cyc = 0;
    int         acc_count = 0;
    int         last_acc_cyc = 0;
    logic [7:0] cur_a = 8'd0;
    logic [7:0] cur_b = 8'd0;
    logic [7:0] exp_y = 8'd0;
    bit         exp_to = 0;
    int         cur_d = 0;
    bit         cur_stale = 0;
    int         run_idx = -1;

    logic [7:0] resp_q[$];

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic boundFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=no-event expected=event at t=%0t", name, $time);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: tracks the outstanding transaction by its position in time since acceptance
    always @(posedge clock) begin
        m_cyc++;
        if (reset) begin
            m_init = 1;
            m_busy = 0;
        end else if (m_init) begin
            if (m_busy) begin
                if ((m_bypass || m_rel >= m_c + 2) && rsp_ready)
                    m_busy = 0;
                else
                    m_rel++;
            end else if (req_valid) begin
                cur_a     = req_a;
                cur_b     = req_b;
                cur_d     = cfg_d;
                cur_stale = cfg_stale;
                m_bypass  = (req_a == 8'd0) || (req_b == 8'd0);
                if (m_bypass) begin
                    exp_y  = req_a | req_b;
                    exp_to = 0;
                    m_c    = 0;
                end else begin
                    int cap;
                    cap = (cfg_d < 1) ? 1 : cfg_d;
                    if (cap <= TO - 1) begin
                        m_c    = cap;
                        exp_y  = 8'(ref_gcd(int'(req_a), int'(req_b)));
                        exp_to = 0;
                    end else begin
                        m_c    = TO - 1;
                        exp_y  = 8'd0;
                        exp_to = 1;
                    end
                end
                m_rel        = 0;
                m_busy       = 1;
                last_acc_cyc = m_cyc;
                acc_count++;
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clock) begin
        if (m_init) begin
            bit e_resp, e_run, e_load;
            e_resp = m_busy && (m_bypass || m_rel >= m_c + 2);
            e_run  = m_busy && !m_bypass && m_rel >= 1 && m_rel <= m_c + 1;
            e_load = m_busy && !m_bypass && m_rel == 0;
            checkOutput("req_ready", int'(req_ready), int'(!m_busy));
            checkOutput("rsp_valid", int'(rsp_valid), int'(e_resp));
            checkOutput("gcd_run", int'(gcd_run), int'(e_run));
            if (e_resp) begin
                checkOutput("rsp_y", int'(rsp_y), int'(exp_y));
                checkOutput("rsp_timeout", int'(rsp_timeout), int'(exp_to));
            end
            if (e_load || e_run) begin
                checkOutput("gcd_a", int'(gcd_a), int'(cur_a));
                checkOutput("gcd_b", int'(gcd_b), int'(cur_b));
            end
            if (rsp_valid && rsp_ready) resp_q.push_back(rsp_y);
        end
    end

    // Behavioural core: ready from RUN cycle cur_d on, optional stale ready with junk on cycle 0
    initial begin
        gcd_ready = 1'b0;
        gcd_y     = 8'd0;
        forever begin
            @(posedge clock);
            #1;
            if (gcd_run) run_idx++;
            else run_idx = -1;
            if (gcd_run && (run_idx >= cur_d || (cur_stale && run_idx == 0))) begin
                gcd_ready = 1'b1;
                if (run_idx < cur_d) gcd_y = 8'hEE;
                else gcd_y = 8'(ref_gcd(int'(gcd_a), int'(gcd_b)));
            end else begin
                gcd_ready = 1'b0;
                gcd_y     = 8'($urandom_range(0, 255));
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rsp_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int d,
                                 input bit stale, input bit keep);
        int c0;
        bit ok;
        c0 = acc_count;
        ok = 0;
        req_a     = a;
        req_b     = b;
        cfg_d     = d;
        cfg_stale = stale;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (acc_count != c0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) boundFail("accept_wait");
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic waitResp(output int lat, output logic [7:0] y, output logic to);
        bit ok;
        int n;
        ok  = 0;
        n   = 0;
        lat = -1;
        y   = 8'd0;
        to  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            n++;
            if (rsp_valid) begin
                ok  = 1;
                lat = n - 1;
                y   = rsp_y;
                to  = rsp_timeout;
                break;
            end
        end
        if (!ok) boundFail("resp_wait");
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (!m_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) boundFail("idle_wait");
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, int'(req_ready), 1);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_rsp_y"}, int'(rsp_y), 0);
        checkOutput({tag, "_rsp_timeout"}, int'(rsp_timeout), 0);
        checkOutput({tag, "_gcd_a"}, int'(gcd_a), 0);
        checkOutput({tag, "_gcd_b"}, int'(gcd_b), 0);
        checkOutput({tag, "_gcd_run"}, int'(gcd_run), 0);
    endtask

    initial begin
        int         lat;
        int         a1;
        logic [7:0] y;
        logic       to;
        logic [7:0] ra;
        logic [7:0] rb;
        int         d;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = 8'd0;
        req_b     = 8'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetValues("init");
        @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] scenario 1: (6,2) ready after 3 RUN cycles");
        applyStimulus(8'd6, 8'd2, 3, 0, 0);
        waitResp(lat, y, to);
        checkOutput("s1_y", int'(y), 2);
        checkOutput("s1_to", int'(to), 0);
        checkOutput("s1_lat", lat, 5);
        waitIdle();

        $display("[TB] scenario 2: back-to-back (12,12) then (9,5)");
        resp_q.delete();
        applyStimulus(8'd12, 8'd12, 2, 0, 1);
        a1 = last_acc_cyc;
        applyStimulus(8'd9, 8'd5, 3, 0, 0);
        checkOutput("s2_accept_gap", last_acc_cyc - a1, 6);
        waitIdle();
        @(negedge clock);
        checkOutput("s2_count", resp_q.size(), 2);
        if (resp_q.size() >= 2) begin
            checkOutput("s2_first", int'(resp_q[0]), 12);
            checkOutput("s2_second", int'(resp_q[1]), 1);
        end

        $display("[TB] scenario 3: zero bypass (0,7) then (0,0)");
        applyStimulus(8'd0, 8'd7, 5, 0, 0);
        waitResp(lat, y, to);
        checkOutput("s3a_y", int'(y), 7);
        checkOutput("s3a_lat", lat, 0);
        waitIdle();
        applyStimulus(8'd0, 8'd0, 5, 0, 0);
        waitResp(lat, y, to);
        checkOutput("s3b_y", int'(y), 0);
        checkOutput("s3b_to", int'(to), 0);
        checkOutput("s3b_lat", lat, 0);
        waitIdle();

        $display("[TB] scenario 4: timeout, then ready on the timeout cycle");
        applyStimulus(8'd15, 8'd25, 200, 0, 0);
        waitResp(lat, y, to);
        checkOutput("s4a_y", int'(y), 0);
        checkOutput("s4a_to", int'(to), 1);
        checkOutput("s4a_lat", lat, TO + 1);
        waitIdle();
        applyStimulus(8'd48, 8'd36, TO - 1, 0, 0);
        waitResp(lat, y, to);
        checkOutput("s4b_y", int'(y), 12);
        checkOutput("s4b_to", int'(to), 0);
        checkOutput("s4b_lat", lat, TO + 1);
        waitIdle();

        $display("[TB] scenario 5: stale ready on first RUN cycle");
        applyStimulus(8'd21, 8'd14, 2, 1, 0);
        waitResp(lat, y, to);
        checkOutput("s5_y", int'(y), 7);
        checkOutput("s5_lat", lat, 4);
        waitIdle();

        $display("[TB] scenario 6: held response, then reset mid-RUN");
        rsp_mode = 2;
        applyStimulus(8'd10, 8'd4, 2, 0, 0);
        waitResp(lat, y, to);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("s6_hold_y", int'(rsp_y), 2);
            checkOutput("s6_hold_req_ready", int'(req_ready), 0);
        end
        rsp_mode = 0;
        applyStimulus(8'd9, 8'd6, 40, 0, 0);
        repeat (5) @(negedge clock);
        checkOutput("s6_midrun", int'(gcd_run), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkResetValues("s6_reset");
        @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] randomized traffic");
        rsp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            case ($urandom_range(0, 9))
                0: d = $urandom_range(TO, TO + 16);
                1: d = TO - 1;
                default: d = $urandom_range(0, 12);
            endcase
            applyStimulus(ra, rb, d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        waitIdle();
        repeat (3) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
